swc_packet_mem_write_pump: RTL and testbench
============================================

# swc_packet_mem_write_pump

Write-side pump of the switch core packet memory. It collects `MULTIPLY` narrow input words into one wide memory line and writes that line during the time slot granted by `sync_i`. It tracks line position inside the current page and requests the next page near the page end. On each page switch it emits a linked-list write that chains the current page to the next one.

## Interface
- `PAGE_ADDR_BITS`, default 10: page address width.
- `PAGE_SIZE`, default 128: input words per page; must be a multiple of `MULTIPLY`. `LINES = PAGE_SIZE/MULTIPLY` (default 8).
- `INPUT_WIDTH`, default 20: input word width.
- `MULTIPLY`, default 16: input words per memory line.
- `clk_i` in 1: the single clock.
- `rst_n_i` in 1: asynchronous, active-high reset.
- `pgaddr_i` in PAGE_ADDR_BITS: page address, valid while `pgreq_i` is high.
- `pgreq_i` in 1: page supply strobe, one cycle.
- `pgend_o` out 1: the current page is on its last line and no next page is pending.
- `pckstart_i` in 1: first word of a packet.
- `drdy_i` in 1: `d_i` is valid.
- `full_o` out 1: the block cannot accept data this cycle.
- `flush_i` in 1: close the partial line and write it.
- `sync_i` in 1: memory write slot for this port.
- `ll_addr_o` out PAGE_ADDR_BITS: linked-list entry address, which is the page being left.
- `ll_data_o` out PAGE_ADDR_BITS: linked-list entry data, which is the next page.
- `ll_wr_req_o` out 1: linked-list write request.
- `ll_wr_done_i` in 1: linked-list write acknowledge.
- `d_i` in INPUT_WIDTH: input word.
- `q_o` out INPUT_WIDTH*MULTIPLY: memory line.
- `we_o` out 1: memory write enable, one cycle.

## Operation
- Reset drives every output to 0, clears the line register and counters, sets the current page to 0 and clears next-valid.
- **Accepting data.** A word is accepted when `drdy_i=1`, `full_o=0` and `flush_i=0`.
  - The word is stored in slot `cnt`. Slot 0 occupies the LSBs `[INPUT_WIDTH-1:0]`.
  - Then `cnt` increments.
  - When `cnt` reaches `MULTIPLY`, the line becomes ready.
- **Flush.** `flush_i=1` marks the line ready if `cnt>0`. It is ignored if `cnt=0`. `d_i` is ignored in that cycle, even with `drdy_i=1`. Unfilled slots are 0 because the register is cleared after every write.
- **Memory write.** At a clock edge where the line is ready and `sync_i=1`:
  - `q_o` takes the line and `we_o` goes high for exactly one cycle.
  - The register is cleared, `cnt` returns to 0 and the ready flag is cleared.
  - The line counter `line` increments.
- **`full_o`.** `full_o = ready | stall`, where `stall` means `line=LINES` with no usable next page (see page switch).
- **Page load.** `pgreq_i` together with `pckstart_i` sets current page ← `pgaddr_i` and `line` ← 0. No linked-list write is issued.
- **Next-page registration.** `pgreq_i` without `pckstart_i` stores next ← `pgaddr_i` and sets next-valid. A second request before the switch overwrites the stored page.
- **`pgend_o`.** `pgend_o = (line == LINES-1) & !next_valid`. It drops the cycle after a next page is registered.
- **Page switch.** After the last line of a page is written (`line=LINES`), if next-valid is set and no linked-list request is pending:
  - `ll_addr_o` ← current page, `ll_data_o` ← next page, `ll_wr_req_o` ← 1.
  - Current page ← next page, `line` ← 0, next-valid cleared.
  - Otherwise `stall` holds until both conditions are true.
- **Linked-list handshake.** `ll_wr_req_o` stays high, with `ll_addr_o`/`ll_data_o` stable, until the first cycle `ll_wr_done_i=1`, then drops. Data acceptance continues while the request is outstanding. Only a further page switch waits for it.
- **Flush and pages.** A flush ends a packet but does not reset `line`. The next packet continues in the same page unless it loads a new one.

## Timing
- A word accepted at edge k that completes the line gives `full_o=1` after edge k.
- The write happens at the first edge with ready and `sync_i=1`. `we_o`/`q_o` are valid the following cycle, and `full_o=0` the same cycle.
- `we_o` is never high on two consecutive cycles, because a line needs at least one cycle to refill.
- `pgreq_i` arriving in the same cycle as the write of the last line is honoured, with no stall.
- `ll_wr_done_i` arriving without a pending request is ignored.
- Asynchronous reset mid-operation discards the partial line and any pending linked-list request.

## Test plan
- **Full line.** Reset, then `pgreq_i`+`pckstart_i` with `pgaddr_i=4`, then 16 words 1..16 with `sync_i` pulsed 1 of 16 cycles. Expect:
  - `full_o` high after word 16.
  - One `we_o` at the sync slot with `q_o` = {16,…,2,1} (word 1 in the LSBs).
  - `full_o` low afterwards.
- **Flush.** 5 words then `flush_i`+`drdy_i`. Expect one write with slots 0–4 = 1..5 and slots 5–15 = 0.
- **Page end and switch.**
  - Writing `LINES-1` (7) lines to page 4 raises `pgend_o`.
  - `pgreq_i` with `pgaddr_i=5` drops `pgend_o`.
  - After line 8 is written: `ll_addr_o=4`, `ll_data_o=5`, `ll_wr_req_o` held until `ll_wr_done_i` arrives 5 cycles later, then low.
- **Page exhaustion without a next page.** Fill 8 lines with no `pgreq_i`. Expect `full_o` held high. A later `pgreq_i` (`pgaddr_i=9`) releases it and issues a linked-list write 4→9.
- **Packet start mid page.** `pgreq_i`+`pckstart_i` with `pgaddr_i=12` after 3 lines. Expect no linked-list request, `line`=0 and `pgend_o` after 7 further lines.
- **Reset mid-line.** Assert reset after 7 words. Expect all outputs 0, and no `we_o` until 16 new words and a sync slot.

Source files
------------

// File: rtl/swc_packet_mem_write_pump.sv
// Write-side pump of the switch packet memory: packs MULTIPLY input words into
// one memory line, writes it in the granted sync slot and chains pages in the linked list.
module swc_packet_mem_write_pump #(
    parameter int PAGE_ADDR_BITS = 10,
    parameter int PAGE_SIZE      = 128,
    parameter int INPUT_WIDTH    = 20,
    parameter int MULTIPLY       = 16
) (
    input  logic                            clk_i,
    input  logic                            rst_n_i,
    input  logic [PAGE_ADDR_BITS-1:0]       pgaddr_i,
    input  logic                            pgreq_i,
    output logic                            pgend_o,
    input  logic                            pckstart_i,
    input  logic                            drdy_i,
    output logic                            full_o,
    input  logic                            flush_i,
    input  logic                            sync_i,
    output logic [PAGE_ADDR_BITS-1:0]       ll_addr_o,
    output logic [PAGE_ADDR_BITS-1:0]       ll_data_o,
    output logic                            ll_wr_req_o,
    input  logic                            ll_wr_done_i,
    input  logic [INPUT_WIDTH-1:0]          d_i,
    output logic [INPUT_WIDTH*MULTIPLY-1:0] q_o,
    output logic                            we_o
);

    localparam int LINES  = PAGE_SIZE / MULTIPLY;
    localparam int CNT_W  = $clog2(MULTIPLY + 1);
    localparam int LINE_W = $clog2(LINES + 1);
    localparam int Q_W    = INPUT_WIDTH * MULTIPLY;

    logic [Q_W-1:0]            buf_r, buf_nxt_s, q_r;
    logic [CNT_W-1:0]          cnt_r, cnt_nxt_s;
    logic                      ready_r, ready_nxt_s, we_r;
    logic [LINE_W-1:0]         line_r, line_nxt_s;
    logic [PAGE_ADDR_BITS-1:0] cur_page_r, cur_page_nxt_s;
    logic [PAGE_ADDR_BITS-1:0] next_page_r, next_page_nxt_s;
    logic                      next_valid_r, next_valid_nxt_s;
    logic [PAGE_ADDR_BITS-1:0] ll_addr_r, ll_addr_nxt_s;
    logic [PAGE_ADDR_BITS-1:0] ll_data_r, ll_data_nxt_s;
    logic                      ll_req_r, ll_req_nxt_s;

    logic last_s, stall_s, full_s, write_s, accept_s, load_s, switch_s;

    // Control decode; a page switch is only possible when the linked-list port is free.
    always_comb begin
        last_s   = (line_r == LINE_W'(LINES));
        stall_s  = last_s & ~(next_valid_r & ~ll_req_r);
        full_s   = ready_r | stall_s;
        write_s  = ready_r & sync_i;
        accept_s = drdy_i & ~full_s & ~flush_i;
        load_s   = pgreq_i & pckstart_i;
        switch_s = last_s & next_valid_r & ~ll_req_r & ~load_s;
    end

    // Line assembly: a write has priority, then flush, then word acceptance.
    always_comb begin
        buf_nxt_s   = buf_r;
        cnt_nxt_s   = cnt_r;
        ready_nxt_s = ready_r;
        if (write_s) begin
            buf_nxt_s   = '0;
            cnt_nxt_s   = '0;
            ready_nxt_s = 1'b0;
        end else if (flush_i) begin
            ready_nxt_s = ready_r | (cnt_r != '0);
        end else if (accept_s) begin
            for (int i = 0; i < MULTIPLY; i++) begin
                buf_nxt_s[i*INPUT_WIDTH +: INPUT_WIDTH] =
                    (cnt_r == CNT_W'(i)) ? d_i : buf_r[i*INPUT_WIDTH +: INPUT_WIDTH];
            end
            cnt_nxt_s   = cnt_r + CNT_W'(1);
            ready_nxt_s = (cnt_r == CNT_W'(MULTIPLY - 1));
        end else begin
            ready_nxt_s = ready_r;
        end
    end

    // Page tracking: a packet-start load wins over a switch, which wins over a line advance.
    always_comb begin
        line_nxt_s       = line_r;
        cur_page_nxt_s   = cur_page_r;
        next_page_nxt_s  = next_page_r;
        next_valid_nxt_s = next_valid_r;
        ll_addr_nxt_s    = ll_addr_r;
        ll_data_nxt_s    = ll_data_r;
        ll_req_nxt_s     = ll_req_r;
        if (ll_req_r && ll_wr_done_i) begin
            ll_req_nxt_s = 1'b0;
        end else begin
            ll_req_nxt_s = ll_req_r;
        end
        if (load_s) begin
            cur_page_nxt_s = pgaddr_i;
            line_nxt_s     = '0;
        end else if (switch_s) begin
            ll_addr_nxt_s    = cur_page_r;
            ll_data_nxt_s    = next_page_r;
            ll_req_nxt_s     = 1'b1;
            cur_page_nxt_s   = next_page_r;
            line_nxt_s       = '0;
            next_valid_nxt_s = 1'b0;
        end else if (write_s) begin
            line_nxt_s = line_r + LINE_W'(1);
        end else begin
            line_nxt_s = line_r;
        end
        // A fresh next page supplied during the switch becomes the new pending page.
        if (pgreq_i && !pckstart_i) begin
            next_page_nxt_s  = pgaddr_i;
            next_valid_nxt_s = 1'b1;
        end else begin
            next_page_nxt_s = next_page_nxt_s;
        end
    end

    // State and output registers.
    always_ff @(posedge clk_i or posedge rst_n_i) begin
        if (rst_n_i) begin
            buf_r        <= '0;
            cnt_r        <= '0;
            ready_r      <= 1'b0;
            line_r       <= '0;
            cur_page_r   <= '0;
            next_page_r  <= '0;
            next_valid_r <= 1'b0;
            ll_addr_r    <= '0;
            ll_data_r    <= '0;
            ll_req_r     <= 1'b0;
            q_r          <= '0;
            we_r         <= 1'b0;
        end else begin
            buf_r        <= buf_nxt_s;
            cnt_r        <= cnt_nxt_s;
            ready_r      <= ready_nxt_s;
            line_r       <= line_nxt_s;
            cur_page_r   <= cur_page_nxt_s;
            next_page_r  <= next_page_nxt_s;
            next_valid_r <= next_valid_nxt_s;
            ll_addr_r    <= ll_addr_nxt_s;
            ll_data_r    <= ll_data_nxt_s;
            ll_req_r     <= ll_req_nxt_s;
            q_r          <= write_s ? buf_r : q_r;
            we_r         <= write_s;
        end
    end

    assign full_o      = full_s;
    assign pgend_o     = (line_r == LINE_W'(LINES - 1)) & ~next_valid_r;
    assign ll_addr_o   = ll_addr_r;
    assign ll_data_o   = ll_data_r;
    assign ll_wr_req_o = ll_req_r;
    assign q_o         = q_r;
    assign we_o        = we_r;

endmodule

// File: tb/tb_swc_packet_mem_write_pump.sv
// Randomized and directed bench for swc_packet_mem_write_pump against a
// word-queue reference model of line packing and page chaining.
module tb_swc_packet_mem_write_pump;

    localparam int PAB   = 10;
    localparam int IW    = 20;
    localparam int MUL   = 16;
    localparam int LINES = 8;
    localparam int QW    = IW * MUL;

    logic           clk_i = 1'b0;
    logic           rst_n_i;
    logic [PAB-1:0] pgaddr_i;
    logic           pgreq_i, pckstart_i, drdy_i, flush_i, sync_i, ll_wr_done_i;
    logic [IW-1:0]  d_i;
    logic           pgend_o, full_o, ll_wr_req_o, we_o;
    logic [PAB-1:0] ll_addr_o, ll_data_o;
    logic [QW-1:0]  q_o;

    swc_packet_mem_write_pump dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .pgaddr_i(pgaddr_i), .pgreq_i(pgreq_i),
        .pgend_o(pgend_o), .pckstart_i(pckstart_i), .drdy_i(drdy_i), .full_o(full_o),
        .flush_i(flush_i), .sync_i(sync_i), .ll_addr_o(ll_addr_o), .ll_data_o(ll_data_o),
        .ll_wr_req_o(ll_wr_req_o), .ll_wr_done_i(ll_wr_done_i), .d_i(d_i), .q_o(q_o), .we_o(we_o)
    );

    always #5 clk_i = ~clk_i;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    int             m_words[$];
    bit             m_ready, m_nv, m_llreq, m_we;
    int             m_line;
    logic [PAB-1:0] m_page, m_next, m_lla, m_lld;
    logic [QW-1:0]  m_q;

    function automatic logic [QW-1:0] pack_words();
        logic [QW-1:0] v = '0;
        foreach (m_words[i]) v[i*IW +: IW] = IW'(m_words[i]);
        return v;
    endfunction

    function automatic bit m_full();
        return m_ready || (m_line == LINES && !(m_nv && !m_llreq));
    endfunction

    function automatic bit m_pgend();
        return (m_line == LINES - 1) && !m_nv;
    endfunction

    task automatic model_reset();
        m_words.delete();
        m_ready = 0; m_nv = 0; m_llreq = 0; m_we = 0; m_line = 0;
        m_page = '0; m_next = '0; m_lla = '0; m_lld = '0; m_q = '0;
    endtask

    task automatic idle_inputs();
        drdy_i = 0; d_i = '0; flush_i = 0; sync_i = 0;
        pgreq_i = 0; pckstart_i = 0; pgaddr_i = '0; ll_wr_done_i = 0;
    endtask

    // Drive one cycle of inputs, advance the model by the rules, and step past the edge.
    task automatic step(input bit drdy, input int d, input bit flush, input bit sync,
                        input bit pgreq, input bit pck, input int addr, input bit done);
        bit full_now, wrote, sw;
        drdy_i = drdy; d_i = IW'(d); flush_i = flush; sync_i = sync;
        pgreq_i = pgreq; pckstart_i = pck; pgaddr_i = PAB'(addr); ll_wr_done_i = done;
        full_now = m_full();
        wrote = 0;
        m_we = 0;
        if (m_ready && sync) begin
            m_q = pack_words(); m_we = 1; wrote = 1;
            m_words.delete(); m_ready = 0;
        end else if (flush) begin
            if (m_words.size() > 0) m_ready = 1;
        end else if (drdy && !full_now) begin
            m_words.push_back(d & 32'hFFFFF);
            if (m_words.size() == MUL) m_ready = 1;
        end
        sw = (m_line == LINES) && m_nv && !m_llreq && !(pgreq && pck);
        if (m_llreq && done) m_llreq = 0;
        if (pgreq && pck) begin
            m_page = PAB'(addr); m_line = 0;
        end else if (sw) begin
            m_lla = m_page; m_lld = m_next; m_llreq = 1;
            m_page = m_next; m_line = 0; m_nv = 0;
        end else if (wrote) begin
            m_line++;
        end
        if (pgreq && !pck) begin
            m_next = PAB'(addr); m_nv = 1;
        end
        @(posedge clk_i);
        #1;
        idle_inputs();
    endtask

    task automatic write_line();
        for (int i = 0; i < MUL; i++) step(1, int'($urandom_range(0, 20'hFFFFF)), 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        rst_n_i = 1'b1;
        #2;
        model_reset();
        repeat (2) @(posedge clk_i);
        #1;
        rst_n_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_n_i = 1'b1;
        idle_inputs();
        #3;
        n_vec++;
        if ({we_o, full_o, pgend_o, ll_wr_req_o} !== 4'b0000 || q_o !== '0 ||
            ll_addr_o !== '0 || ll_data_o !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: we=%0b full=%0b pgend=%0b llreq=%0b q=%h lla=%0d lld=%0d, want all 0",
                     we_o, full_o, pgend_o, ll_wr_req_o, q_o, ll_addr_o, ll_data_o);
        end
        model_reset();
        @(posedge clk_i);
        #1;
        rst_n_i = 1'b0;
    endtask

    task automatic test_full_line();
        logic [QW-1:0] exp_q = '0;
        for (int i = 0; i < MUL; i++) exp_q[i*IW +: IW] = IW'(i + 1);
        step(0, 0, 0, 0, 1, 1, 4, 0);
        for (int i = 1; i <= MUL; i++) step(1, i, 0, 0, 0, 0, 0, 0);
        n_vec++;
        if (full_o !== 1'b1 || we_o !== 1'b0) begin
            n_err++; $display("FAIL full_line_ready: full=%0b we=%0b, want full=1 we=0", full_o, we_o);
        end
        step(0, 0, 0, 1, 0, 0, 0, 0);
        n_vec++;
        if (we_o !== 1'b1 || q_o !== exp_q || full_o !== 1'b0) begin
            n_err++; $display("FAIL full_line_write: we=%0b full=%0b q=%h, want we=1 full=0 q=%h", we_o, full_o, q_o, exp_q);
        end
        step(0, 0, 0, 1, 0, 0, 0, 0);
        n_vec++;
        if (we_o !== 1'b0) begin
            n_err++; $display("FAIL full_line_single_we: we=%0b, want 0", we_o);
        end
    endtask

    task automatic test_flush();
        logic [QW-1:0] exp_q = '0;
        for (int i = 0; i < 5; i++) exp_q[i*IW +: IW] = IW'(i + 1);
        for (int i = 1; i <= 5; i++) step(1, i, 0, 0, 0, 0, 0, 0);
        step(1, 99, 1, 0, 0, 0, 0, 0);
        n_vec++;
        if (full_o !== 1'b1) begin
            n_err++; $display("FAIL flush_ready: full=%0b, want 1", full_o);
        end
        step(0, 0, 0, 1, 0, 0, 0, 0);
        n_vec++;
        if (we_o !== 1'b1 || q_o !== exp_q) begin
            n_err++; $display("FAIL flush_write: we=%0b q=%h, want we=1 q=%h", we_o, q_o, exp_q);
        end
    endtask

    task automatic test_page_switch();
        repeat (5) write_line();
        n_vec++;
        if (pgend_o !== 1'b1 || full_o !== 1'b0) begin
            n_err++; $display("FAIL pgend_raise: pgend=%0b full=%0b, want pgend=1 full=0", pgend_o, full_o);
        end
        step(0, 0, 0, 0, 1, 0, 5, 0);
        n_vec++;
        if (pgend_o !== 1'b0) begin
            n_err++; $display("FAIL pgend_drop: pgend=%0b, want 0", pgend_o);
        end
        write_line();
        n_vec++;
        if (full_o !== 1'b0 || ll_wr_req_o !== 1'b0) begin
            n_err++; $display("FAIL switch_no_stall: full=%0b llreq=%0b, want 0 0", full_o, ll_wr_req_o);
        end
        step(0, 0, 0, 0, 0, 0, 0, 0);
        n_vec++;
        if (ll_wr_req_o !== 1'b1 || ll_addr_o !== 10'd4 || ll_data_o !== 10'd5) begin
            n_err++; $display("FAIL switch_ll: req=%0b addr=%0d data=%0d, want 1 4 5", ll_wr_req_o, ll_addr_o, ll_data_o);
        end
        for (int c = 0; c < 4; c++) begin
            step(0, 0, 0, 0, 0, 0, 0, 0);
            n_vec++;
            if (ll_wr_req_o !== 1'b1 || ll_addr_o !== 10'd4 || ll_data_o !== 10'd5) begin
                n_err++; $display("FAIL switch_ll_hold: cycle %0d req=%0b addr=%0d data=%0d, want 1 4 5",
                                  c, ll_wr_req_o, ll_addr_o, ll_data_o);
            end
        end
        step(0, 0, 0, 0, 0, 0, 0, 1);
        n_vec++;
        if (ll_wr_req_o !== 1'b0) begin
            n_err++; $display("FAIL switch_ll_done: req=%0b, want 0", ll_wr_req_o);
        end
    endtask

    task automatic test_exhaustion();
        do_reset();
        step(0, 0, 0, 0, 1, 1, 4, 0);
        repeat (LINES) write_line();
        for (int c = 0; c < 5; c++) begin
            step(1, c + 7, 0, 1, 0, 0, 0, 0);
            n_vec++;
            if (full_o !== 1'b1 || pgend_o !== 1'b0 || we_o !== 1'b0) begin
                n_err++; $display("FAIL exhaust_stall: full=%0b pgend=%0b we=%0b, want 1 0 0", full_o, pgend_o, we_o);
            end
        end
        step(0, 0, 0, 0, 1, 0, 9, 0);
        n_vec++;
        if (full_o !== 1'b0) begin
            n_err++; $display("FAIL exhaust_release: full=%0b, want 0", full_o);
        end
        step(0, 0, 0, 0, 0, 0, 0, 0);
        n_vec++;
        if (ll_wr_req_o !== 1'b1 || ll_addr_o !== 10'd4 || ll_data_o !== 10'd9) begin
            n_err++; $display("FAIL exhaust_ll: req=%0b addr=%0d data=%0d, want 1 4 9", ll_wr_req_o, ll_addr_o, ll_data_o);
        end
        step(0, 0, 0, 0, 0, 0, 0, 1);
    endtask

    task automatic test_pckstart_mid_page();
        repeat (3) write_line();
        step(0, 0, 0, 0, 1, 1, 12, 0);
        n_vec++;
        if (ll_wr_req_o !== 1'b0 || pgend_o !== 1'b0) begin
            n_err++; $display("FAIL pckstart_load: llreq=%0b pgend=%0b, want 0 0", ll_wr_req_o, pgend_o);
        end
        repeat (LINES - 2) write_line();
        n_vec++;
        if (pgend_o !== 1'b0) begin
            n_err++; $display("FAIL pckstart_early_pgend: pgend=%0b, want 0", pgend_o);
        end
        write_line();
        n_vec++;
        if (pgend_o !== 1'b1 || ll_wr_req_o !== 1'b0) begin
            n_err++; $display("FAIL pckstart_pgend: pgend=%0b llreq=%0b, want 1 0", pgend_o, ll_wr_req_o);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 3000; c++) begin
            bit pgreq = ($urandom_range(0, 99) < 4);
            step($urandom_range(0, 99) < 75, int'($urandom_range(0, 20'hFFFFF)),
                 $urandom_range(0, 99) < 3, $urandom_range(0, 7) == 0,
                 pgreq, pgreq && ($urandom_range(0, 99) < 30), int'($urandom_range(0, 1023)),
                 $urandom_range(0, 99) < 20);
            n_vec++;
            if (we_o !== m_we || (m_we && q_o !== m_q) || full_o !== m_full() || pgend_o !== m_pgend() ||
                ll_wr_req_o !== m_llreq || ll_addr_o !== m_lla || ll_data_o !== m_lld) begin
                n_err++;
                $display("FAIL random_cycle %0d: we=%0b/%0b full=%0b/%0b pgend=%0b/%0b llreq=%0b/%0b lla=%0d/%0d lld=%0d/%0d q=%h want %h",
                         c, we_o, m_we, full_o, m_full(), pgend_o, m_pgend(), ll_wr_req_o, m_llreq,
                         ll_addr_o, m_lla, ll_data_o, m_lld, q_o, m_q);
            end
        end
    endtask

    task automatic test_reset_mid_line();
        logic [QW-1:0] exp_q = '0;
        do_reset();
        step(0, 0, 0, 0, 1, 1, 3, 0);
        step(0, 0, 0, 0, 1, 0, 6, 0);
        for (int i = 0; i < 7; i++) step(1, 500 + i, 0, 0, 0, 0, 0, 0);
        rst_n_i = 1'b1;
        #2;
        n_vec++;
        if ({we_o, full_o, pgend_o, ll_wr_req_o} !== 4'b0000 || q_o !== '0 ||
            ll_addr_o !== '0 || ll_data_o !== '0) begin
            n_err++;
            $display("FAIL reset_mid_line: we=%0b full=%0b pgend=%0b llreq=%0b lla=%0d lld=%0d, want all 0",
                     we_o, full_o, pgend_o, ll_wr_req_o, ll_addr_o, ll_data_o);
        end
        model_reset();
        @(posedge clk_i);
        #1;
        rst_n_i = 1'b0;
        for (int i = 0; i < MUL; i++) begin
            exp_q[i*IW +: IW] = IW'(1000 + i);
            step(1, 1000 + i, 0, 1, 0, 0, 0, 0);
            n_vec++;
            if (we_o !== 1'b0) begin
                n_err++; $display("FAIL reset_no_early_we: word %0d we=%0b, want 0", i, we_o);
            end
        end
        step(0, 0, 0, 1, 0, 0, 0, 0);
        n_vec++;
        if (we_o !== 1'b1 || q_o !== exp_q) begin
            n_err++; $display("FAIL reset_fresh_line: we=%0b q=%h, want we=1 q=%h", we_o, q_o, exp_q);
        end
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_full_line();
        test_flush();
        test_page_switch();
        test_exhaustion();
        test_pckstart_mid_page();
        test_random();
        test_reset_mid_line();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
